// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage between EX/MEM and MEM/WB
// Optional access timeout/abort enabled by defining MEM_TIMEOUT_EN.

module mem_stage #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] outAlu,
   input  logic [DATA_W-1:0] rs2,
   input  logic [DATA_W-1:0] immPc,
   input  logic [DATA_W-1:0] pcAdd4,
   input  logic [4:0]        rd,
   input  logic              EscReg,
   input  logic              EscMem,
   input  logic              jump,
   input  logic              Branch,
   input  logic              jalr,
   input  logic              lw,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic              stall,
   output logic              redirect,
   output logic [DATA_W-1:0] pc_target,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [4:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              misalign,
   output logic              mem_err
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t state, state_nx;

   logic memop, aligned, access, misal, taken, complete;
   logic req_c, stall_c, abort;

   assign memop   = in_valid & (lw | EscMem);
   assign aligned = (outAlu[1:0] == 2'b00);
   assign access  = memop & aligned;
   assign misal   = memop & ~aligned;

`ifdef MEM_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CW-1:0] wait_cnt;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Upstream holds its outputs while stalled, so address/data in WAIT come
   // straight from the still-stable EX/MEM inputs.
   always_comb begin
      state_nx = state;
      req_c    = 1'b0;
      stall_c  = 1'b0;
      abort    = 1'b0;
      case (state)
         S_IDLE: begin
            if (access) begin
               req_c = 1'b1;
               if (!dmem_ready) begin
                  stall_c  = 1'b1;
                  state_nx = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            req_c   = 1'b1;
            stall_c = 1'b1;
            if (dmem_ready) begin
               stall_c  = 1'b0;
               state_nx = S_IDLE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (wait_cnt == CW'(TIMEOUT)) begin
               req_c    = 1'b0;
               stall_c  = 1'b0;
               abort    = 1'b1;
               state_nx = S_IDLE;
            end
`endif
         end
         default: state_nx = S_IDLE;
      endcase
      if (!reset) begin
         req_c   = 1'b0;
         stall_c = 1'b0;
         abort   = 1'b0;
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         if (state == S_WAIT && state_nx == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end
         if (abort) begin
            mem_err <= 1'b1;
         end
      end
   end
`else
   assign mem_err = 1'b0;
`endif

   assign dmem_req   = req_c;
   assign dmem_we    = EscMem;
   assign dmem_addr  = outAlu;
   assign dmem_wdata = rs2;
   assign stall      = stall_c;

   assign complete  = reset & in_valid & ~stall_c;
   assign taken     = jump | jalr | (Branch & (outAlu == '0));
   assign redirect  = complete & taken;
   assign pc_target = jalr ? {outAlu[DATA_W-1:1], 1'b0} : immPc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid <= 1'b0;
         wb_we    <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
         misalign <= 1'b0;
      end else begin
         wb_valid <= complete;
         wb_we    <= complete & EscReg & (rd != 5'd0) & ~abort & ~misal;
         misalign <= complete & misal;
         if (complete) begin
            wb_rd <= rd;
            if (abort) begin
               wb_data <= '0;
            end else if (lw) begin
               wb_data <= dmem_rdata;
            end else if (jump | jalr) begin
               wb_data <= pcAdd4;
            end else begin
               wb_data <= outAlu;
            end
         end
      end
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Consumes that register's outputs (ALU result, rs2, immPc, pcAdd4, rd and control bits) and performs word loads/stores over a ready-handshake data-memory port.
- Stalls upstream while memory is busy, resolves jump/jalr/branch into a PC redirect, and registers results into the MEM/WB boundary.

Parameters:
- DATA_W, 32, data/address width
- TIMEOUT, 255, maximum WAIT cycles before abort; used only with MEM_TIMEOUT_EN

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  EX/MEM slot holds a real instruction
- outAlu  in  DATA_W  ALU result: memory address, branch compare result, or writeback value
- rs2  in  DATA_W  store data
- immPc  in  DATA_W  branch/jump target
- pcAdd4  in  DATA_W  link value
- rd  in  5  destination register
- EscReg, EscMem, jump, Branch, jalr, lw  in  1 each  control bits from EX/MEM
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  DATA_W  word address, equal to outAlu
- dmem_wdata  out  DATA_W  equal to rs2
- dmem_rdata  in  DATA_W  load data, valid with dmem_ready
- dmem_ready  in  1  access completes this cycle
- stall  out  1  hold EX/MEM and earlier stages
- redirect  out  1  PC must load pc_target
- pc_target  out  DATA_W  new PC
- wb_valid, wb_we  out  1 each  MEM/WB valid and register-write enable
- wb_rd  out  5  MEM/WB destination
- wb_data  out  DATA_W  MEM/WB writeback value
- misalign  out  1  one-cycle pulse on a misaligned access
- mem_err  out  1  sticky timeout flag; constant 0 without MEM_TIMEOUT_EN

Behaviour:
- Reset, asynchronous while low:
  - State goes to IDLE; wait counter is 0.
  - wb_valid, wb_we, wb_rd, wb_data, misalign and mem_err are all 0.
  - dmem_req, stall and redirect are forced 0 combinationally while reset is low.
- Definitions:
  - memop = in_valid & (lw | EscMem).
  - aligned = (outAlu[1:0] == 0).
- IDLE state:
  - If memop & aligned: dmem_req = 1 in the same cycle.
  - If dmem_ready is also 1 that cycle, the access completes in zero wait; otherwise stall = 1 and the next state is WAIT.
- WAIT state:
  - dmem_req = 1 and stall = 1; address, write enable and data are held (inputs are stable because upstream is stalled).
  - On dmem_ready: stall = 0 in that cycle and the next state is IDLE.
- dmem_ready when dmem_req = 0 is ignored.
- Misaligned memop:
  - No request is issued.
  - Completes in 1 cycle with wb_we = 0.
  - misalign pulses on the following cycle, together with the MEM/WB update.
- Completion: an instruction completes in a cycle where in_valid = 1 and stall = 0. On the rising edge ending that cycle:
  - wb_valid <= 1.
  - wb_rd <= rd.
  - wb_we <= EscReg & (rd != 0) & not aborted & not misaligned.
  - wb_data <= dmem_rdata if lw; pcAdd4 if jump or jalr; otherwise outAlu.
- When in_valid = 0, or when stall = 1: wb_valid <= 0 and wb_we <= 0.
- Stores produce wb_we = 0 unless EscReg is set; no forcing is applied.
- Branch resolution is combinational and gated by completion:
  - taken = jump | jalr | (Branch & (outAlu == 0)).
  - redirect = in_valid & ~stall & taken.
  - pc_target = jalr ? {outAlu[DATA_W-1:1], 1'b0} : immPc.
- Latency:
  - Non-memory instruction and zero-wait access: 1 cycle to MEM/WB.
  - N wait cycles: N+1 cycles.
- Throughput: one instruction per cycle when there are no waits.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider counter increments each WAIT cycle.
  - When the counter reaches TIMEOUT without dmem_ready, the access aborts: dmem_req = 0 and stall = 0 that cycle.
  - The instruction completes with wb_we = 0 and wb_data = 0, the state returns to IDLE, and mem_err sets and stays set until reset.
  - The counter clears on entering IDLE.
- When undefined: WAIT persists indefinitely and mem_err is tied to 0.

Test Plan:
- ALU op: in_valid=1, outAlu=0x1234, rd=5, EscReg=1 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234; stall=0 throughout.
- Load with 3 waits: lw=1, outAlu=0x100, dmem_ready after 3 cycles with rdata=0xDEADBEEF -> dmem_req high for 4 cycles, stall high for 3, dmem_addr=0x100, then wb_data=0xDEADBEEF, wb_we=1.
- Zero-wait store: EscMem=1, rs2=0xA5A5A5A5, outAlu=0x200, EscReg=0, dmem_ready=1 same cycle -> dmem_we=1, dmem_wdata=0xA5A5A5A5, stall=0, then wb_we=0.
- Branches:
  - Branch=1, outAlu=0, immPc=0x80 -> redirect=1, pc_target=0x80.
  - Branch=1, outAlu=1 -> redirect=0.
  - jalr=1, outAlu=0x301, rd=1, pcAdd4=0x44 -> pc_target=0x300, then wb_data=0x44.
- Misaligned or reset: lw with outAlu=0x102 -> no dmem_req, misalign pulse, wb_we=0. Reset low mid-WAIT -> dmem_req and stall drop immediately, wb_valid=0.
- With MEM_TIMEOUT_EN and TIMEOUT=4: dmem_ready held 0 -> abort after the 4th WAIT cycle, mem_err=1 and sticky, wb_we=0, next instruction proceeds.
